// File: rtl/aes_pkg.sv
// Shared AES key-schedule helpers: S-box table, rcon stepping, key-length legality and
// NK/NR derivation, plus the expander FSM state type.
package aes_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GEN,
    ST_DRAIN
  } kx_state_t;

  localparam logic [7:0] RCON_INIT = 8'h01;

  // Forward S-box, entry 0 in the most significant byte.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[{~b, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic key_bits_ok(input int unsigned kb);
    return (kb == 128) || (kb == 192) || (kb == 256);
  endfunction

  function automatic int unsigned nk_of(input int unsigned kb);
    return kb / 32;
  endfunction

  function automatic int unsigned nr_of(input int unsigned kb);
    return (kb / 32) + 6;
  endfunction

endpackage

// File: rtl/aes_subword.sv
// SubWord with optional RotWord in front; the single S-box path of the key expander.
module aes_subword
  import aes_pkg::*;
(
  input  logic [31:0] word,
  input  logic        rot,
  output logic [31:0] sub_c
);

  logic [31:0] sel;

  assign sel = rot ? {word[23:0], word[31:24]} : word;

  for (genvar b = 0; b < 4; b++) begin : g_sbox
    assign sub_c[8*b +: 8] = sbox(sel[8*b +: 8]);
  end

endmodule

// File: rtl/aes_key_expander.sv
// Iterative AES-128/192/256 key schedule streaming round keys 0..NR over valid/ready.
// Define AES_KEY_STORE_EN to keep every round key in a readable register array.
module aes_key_expander
  import aes_pkg::*;
#(
  parameter int unsigned KEY_BITS = 128
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [255:0] key_in,
  output logic         busy,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [127:0] rk_data,
  output logic [3:0]   rk_idx,
  output logic         done
`ifdef AES_KEY_STORE_EN
  ,
  input  logic [3:0]   rk_rd_idx,
  output logic [127:0] rk_rd_data
`endif
);

  localparam int unsigned NK   = nk_of(KEY_BITS);
  localparam int unsigned NR   = nr_of(KEY_BITS);
  localparam int unsigned LAST = 4 * NR + 3;
  localparam int unsigned BACK = 8 - NK;

  if (!key_bits_ok(KEY_BITS)) begin : g_bad_key_bits
    $error("aes_key_expander: KEY_BITS must be 128, 192 or 256");
  end

  kx_state_t     state, state_nxt;
  logic          busy_nxt, done_nxt;
  logic [31:0]   win [8];
  logic [95:0]   words_q;
  logic [5:0]    word_cnt;
  logic [2:0]    nk_pos;
  logic [7:0]    rcon;
  logic          start_go, accept, gen_en, transfer, last_word;
  logic [31:0]   prev_w, back_w, sub_w, new_w;
  logic [255:0]  key_al;

  assign start_go  = (state == ST_IDLE) && start;
  assign accept    = rk_valid && rk_ready;
  // Only the word that completes a round key can collide with an unaccepted output.
  assign gen_en    = (state == ST_GEN) && !((word_cnt[1:0] == 2'd3) && rk_valid && !rk_ready);
  assign transfer  = gen_en && (word_cnt[1:0] == 2'd3);
  assign last_word = gen_en && (word_cnt == 6'(LAST));
  assign prev_w    = win[7];
  assign back_w    = win[3'(BACK)];
  // Right-aligned key lands its words in the window exactly where w[i-NK] is read.
  assign key_al    = key_in >> (32 * BACK);

  aes_subword u_subword (
    .word  (prev_w),
    .rot   (nk_pos == 3'd0),
    .sub_c (sub_w)
  );

  always_comb begin
    new_w = back_w ^ prev_w;
    if (word_cnt < 6'(NK)) begin
      new_w = back_w;
    end else if (nk_pos == 3'd0) begin
      new_w = back_w ^ sub_w ^ {rcon, 24'h000000};
    end else if ((NK == 8) && (nk_pos == 3'd4)) begin
      new_w = back_w ^ sub_w;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    busy_nxt  = 1'b0;
    case (state)
      ST_IDLE:  if (start) state_nxt = ST_GEN;
      ST_GEN:   if (last_word) state_nxt = ST_DRAIN;
      ST_DRAIN: begin
        if (accept) begin
          state_nxt = ST_IDLE;
          done_nxt  = 1'b1;
        end
      end
      default:  state_nxt = ST_IDLE;
    endcase
    // Busy covers the done cycle so a start coinciding with done never shows a gap.
    busy_nxt = (state_nxt != ST_IDLE) || done_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win      <= '{default: '0};
      words_q  <= '0;
      word_cnt <= '0;
      nk_pos   <= '0;
      rcon     <= RCON_INIT;
      rk_valid <= 1'b0;
      rk_data  <= '0;
      rk_idx   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      busy <= busy_nxt;
      done <= done_nxt;
      if (start_go) begin
        for (int j = 0; j < 8; j++) win[j] <= key_al[32*(7-j) +: 32];
        word_cnt <= '0;
        nk_pos   <= '0;
        rcon     <= RCON_INIT;
      end else if (gen_en) begin
        for (int j = 0; j < 7; j++) win[j] <= win[j+1];
        win[7]   <= new_w;
        words_q  <= {words_q[63:0], new_w};
        word_cnt <= word_cnt + 6'd1;
        nk_pos   <= (nk_pos == 3'(NK - 1)) ? 3'd0 : nk_pos + 3'd1;
        if ((word_cnt >= 6'(NK)) && (nk_pos == 3'd0)) rcon <= xtime(rcon);
      end
      if (transfer) begin
        rk_valid <= 1'b1;
        rk_data  <= {words_q, new_w};
        rk_idx   <= word_cnt[5:2];
      end else if (accept) begin
        rk_valid <= 1'b0;
      end
    end
  end

`ifdef AES_KEY_STORE_EN
  logic [127:0] store [NR+1];

  always_ff @(posedge clk) begin
    if (transfer) store[word_cnt[5:2]] <= {words_q, new_w};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    rk_rd_data <= '0;
    else if (rk_rd_idx <= 4'(NR))  rk_rd_data <= store[rk_rd_idx];
    else                           rk_rd_data <= '0;
  end
`endif

endmodule
